// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: round-robin owner arbitration for the shared snoop bus, with
// one turnaround cycle between owners and a tenure limit that revokes long grants.
module com_bus_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 64,
    parameter int HOLD_W   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] Com_Bus_Req,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt,
    output logic               Gnt_valid,
    output logic [IDX_W-1:0]   Gnt_owner,
    output logic               Hold_timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 valid_q, valid_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic                 timeout_q, timeout_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 found;
    logic [IDX_W-1:0]     win;
    logic [IDX_W-1:0]     ptr_next;
    int                   idx;

    // Scan from the highest offset down so the requester closest to ptr is written last.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (Com_Bus_Req[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    assign ptr_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            GRANT: begin
                hold_d = hold_q + 1'b1;
                if (!Com_Bus_Req[owner_q] || (MAX_HOLD != 0 && hold_q == HOLD_LAST)) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    ptr_d     = ptr_next;
                    timeout_d = Com_Bus_Req[owner_q];
                end
            end
            default: begin
                state_d = found ? GRANT : IDLE;
                gnt_d   = found ? (NUM_REQ'(1) << win) : '0;
                owner_d = found ? win : owner_q;
                hold_d  = found ? '0 : hold_q;
            end
        endcase
        valid_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            owner_q   <= '0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            owner_q   <= owner_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign Com_Bus_Gnt  = gnt_q;
    assign Gnt_valid    = valid_q;
    assign Gnt_owner    = owner_q;
    assign Hold_timeout = timeout_q;
endmodule

// File: tb/tb_com_bus_arbiter.sv
// tb_com_bus_arbiter: directed vector table plus hand-written timeout and reset
// sequences; each row drives inputs for one cycle and checks the registered outputs.
module tb_com_bus_arbiter;
    typedef struct {
        logic       rn;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] own;
        logic       tmo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic       valid;
    logic [2:0] owner;
    logic       tmo;
    int         checks = 0;
    int         failures = 0;
    vec_t       tbl[$];

    com_bus_arbiter #(.NUM_REQ(8), .IDX_W(3), .MAX_HOLD(4), .HOLD_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Com_Bus_Req(req),
        .Com_Bus_Gnt(gnt),
        .Gnt_valid(valid),
        .Gnt_owner(owner),
        .Hold_timeout(tmo)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rn, input logic [7:0] rq, input logic [7:0] eg,
                       input logic [2:0] eo, input logic et);
        vec_t v;
        v = '{rn, rq, eg, eo, et};
        tbl.push_back(v);
    endtask

    task automatic step(input string name, input logic rn, input logic [7:0] rq,
                        input logic [7:0] eg, input logic [2:0] eo, input logic et);
        rst_n = rn;
        req   = rq;
        @(posedge clk);
        #1;
        checks += 5;
        if (gnt !== eg) begin
            failures++;
            $display("FAIL %s gnt: got %h expected %h", name, gnt, eg);
        end
        if (valid !== (eg != 8'h00)) begin
            failures++;
            $display("FAIL %s valid: got %b expected %b", name, valid, eg != 8'h00);
        end
        if (owner !== eo) begin
            failures++;
            $display("FAIL %s owner: got %0d expected %0d", name, owner, eo);
        end
        if (tmo !== et) begin
            failures++;
            $display("FAIL %s timeout: got %b expected %b", name, tmo, et);
        end
        if ($countones(gnt) > 1) begin
            failures++;
            $display("FAIL %s onehot: got %h expected at most one bit", name, gnt);
        end
    endtask

    initial begin
        // reset, single request 2, release leaves ptr at 3
        add(0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h04, 8'h04, 2, 0);
        add(1, 8'h04, 8'h04, 2, 0);
        add(1, 8'h00, 8'h00, 2, 0);
        add(1, 8'h00, 8'h00, 2, 0);
        add(1, 8'h0C, 8'h08, 3, 0);
        add(1, 8'h04, 8'h00, 3, 0);
        add(1, 8'h04, 8'h04, 2, 0);
        add(1, 8'h00, 8'h00, 2, 0);
        add(1, 8'h00, 8'h00, 2, 0);
        // all requesting, each owner drops after two grant cycles
        for (int i = 0; i < 7; i++) begin
            automatic logic [2:0] o = 3'(3 + i);
            automatic logic [7:0] b = 8'h01 << o;
            add(1, 8'hFF, b, o, 0);
            add(1, 8'hFF, b, o, 0);
            add(1, ~b, 8'h00, o, 0);
        end
        add(1, 8'h00, 8'h00, 1, 0);
        // wrap from 7 to 0 and back to 7
        add(1, 8'h80, 8'h80, 7, 0);
        add(1, 8'h01, 8'h00, 7, 0);
        add(1, 8'h81, 8'h01, 0, 0);
        add(1, 8'h80, 8'h00, 0, 0);
        add(1, 8'h80, 8'h80, 7, 0);
        add(1, 8'h00, 8'h00, 7, 0);
        add(1, 8'h00, 8'h00, 7, 0);
        // one-cycle glitch on 4 during owner 2's tenure is never granted
        add(1, 8'h04, 8'h04, 2, 0);
        add(1, 8'h14, 8'h04, 2, 0);
        add(1, 8'h04, 8'h04, 2, 0);
        add(1, 8'h00, 8'h00, 2, 0);
        add(1, 8'h00, 8'h00, 2, 0);
        add(1, 8'h00, 8'h00, 2, 0);
        // ptr=5 with requests {2,6}: 6 wins
        add(1, 8'h10, 8'h10, 4, 0);
        add(1, 8'h00, 8'h00, 4, 0);
        add(1, 8'h44, 8'h40, 6, 0);
        add(1, 8'h00, 8'h00, 6, 0);
        add(1, 8'h00, 8'h00, 6, 0);

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].rn, tbl[i].req, tbl[i].gnt, tbl[i].own, tbl[i].tmo);

        // timeout: 3 holds forever; alone it is re-granted, with 5 present 5 wins
        for (int i = 0; i < 4; i++) step("to_hold", 1, 8'h08, 8'h08, 3, 0);
        step("to_revoke", 1, 8'h08, 8'h00, 3, 1);
        for (int i = 0; i < 4; i++) step("to_regrant", 1, 8'h08, 8'h08, 3, 0);
        step("to_revoke2", 1, 8'h28, 8'h00, 3, 1);
        step("to_other", 1, 8'h28, 8'h20, 5, 0);
        step("to_drop", 1, 8'h00, 8'h00, 5, 0);
        step("to_idle", 1, 8'h00, 8'h00, 5, 0);

        // reset during 6's tenure: no timeout pulse, ptr back to 0 so 1 beats 6
        step("rst_g6", 1, 8'h40, 8'h40, 6, 0);
        step("rst_g6b", 1, 8'h40, 8'h40, 6, 0);
        step("rst_mid", 0, 8'h42, 8'h00, 0, 0);
        step("rst_after", 1, 8'h42, 8'h02, 1, 0);
        step("rst_drop", 1, 8'h00, 8'h00, 1, 0);
        step("rst_idle", 1, 8'h00, 8'h00, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
